// File: rtl/sdram_cmd_pkg.sv
// SDRAM_PKG: shared types and constants for the SDRAM command issuer.
//   op_t     - command opcodes accepted on the request interface
//   cmd_t    - request payload {op, bank, addr, data}
//   PIN_*    - {CS_N, RAS_N, CAS_N, WE_N} encodings driven onto the SDRAM
//   cnt_load - value loaded into a spacing counter for a t-cycle gap
//   cnt_dec  - saturating decrement of a spacing counter
package SDRAM_PKG;

  localparam int BA_W     = 2;
  localparam int A_W      = 13;
  localparam int DQ_W     = 16;
  localparam int CNT_W    = 8;
  localparam int PALL_BIT = 10;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_MRS,
    OP_REF,
    OP_PRE,
    OP_ACT,
    OP_READ,
    OP_WRITE
  } op_t;

  typedef struct packed {
    op_t             op;
    logic [BA_W-1:0] bank;
    logic [A_W-1:0]  addr;
    logic [DQ_W-1:0] data;
  } cmd_t;

  localparam logic [3:0] PIN_NOP   = 4'b0111;
  localparam logic [3:0] PIN_MRS   = 4'b0000;
  localparam logic [3:0] PIN_REF   = 4'b0001;
  localparam logic [3:0] PIN_PRE   = 4'b0010;
  localparam logic [3:0] PIN_ACT   = 4'b0011;
  localparam logic [3:0] PIN_READ  = 4'b0101;
  localparam logic [3:0] PIN_WRITE = 4'b0100;

  // A counter loaded with t-1 reaches 0 exactly t cycles after the accept.
  function automatic logic [CNT_W-1:0] cnt_load(input int t);
    if (t <= 1) return '0;
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/sdram_cmd_bank_timer.sv
// sdram_bank_timer: per-bank open flag and spacing counters.
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_act, i_pre, i_wr      - legal ACT / PRE / WRITE issued to this bank
//   o_open                  - bank has an open row
//   o_rp_ok                 - PRE->ACT/REF gap met
//   o_rcd_ok                - ACT->READ/WRITE gap met
//   o_ras_ok                - ACT->PRE gap met
//   o_rc_ok                 - ACT->ACT gap met
//   o_dpl_ok                - WRITE->PRE gap met
module sdram_bank_timer
  import SDRAM_PKG::*;
#(
  parameter int tRC  = 9,
  parameter int tRAS = 6,
  parameter int tRP  = 3,
  parameter int tRCD = 3,
  parameter int tDPL = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_act,
  input  logic i_pre,
  input  logic i_wr,
  output logic o_open,
  output logic o_rp_ok,
  output logic o_rcd_ok,
  output logic o_ras_ok,
  output logic o_rc_ok,
  output logic o_dpl_ok
);

  logic             r_open;
  logic [CNT_W-1:0] r_rp;
  logic [CNT_W-1:0] r_rcd;
  logic [CNT_W-1:0] r_ras;
  logic [CNT_W-1:0] r_rc;
  logic [CNT_W-1:0] r_dpl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_open <= 1'b0;
      r_rp   <= '0;
      r_rcd  <= '0;
      r_ras  <= '0;
      r_rc   <= '0;
      r_dpl  <= '0;
    end else begin
      // ACT and PRE never arrive together: one command is issued per cycle.
      if (i_act)      r_open <= 1'b1;
      else if (i_pre) r_open <= 1'b0;
      r_rp  <= i_pre ? cnt_load(tRP)  : cnt_dec(r_rp);
      r_rcd <= i_act ? cnt_load(tRCD) : cnt_dec(r_rcd);
      r_ras <= i_act ? cnt_load(tRAS) : cnt_dec(r_ras);
      r_rc  <= i_act ? cnt_load(tRC)  : cnt_dec(r_rc);
      r_dpl <= i_wr  ? cnt_load(tDPL) : cnt_dec(r_dpl);
    end
  end

  assign o_open   = r_open;
  assign o_rp_ok  = (r_rp  == '0);
  assign o_rcd_ok = (r_rcd == '0);
  assign o_ras_ok = (r_ras == '0);
  assign o_rc_ok  = (r_rc  == '0);
  assign o_dpl_ok = (r_dpl == '0);

endmodule

// File: rtl/sdram_cmd.sv
// sdram_cmd: accepts one command per handshake, enforces SDRAM timing and
// bank-state legality, and drives the command onto the SDRAM pins for one
// cycle after acceptance.
//   CLK, RESET_IN              - clock, synchronous active-high reset
//   CMD_DATA_IN, CMD_REQ_IN    - request payload and valid
//   CMD_ACK_OUT                - request accepted this cycle (combinational)
//   BANK_ACTIVE_OUT            - at least one bank has an open row
//   ERROR_OUT                  - pulse after an illegal command was accepted
//   SD_CS_N..SD_WE_N           - SDRAM command pins
//   SD_BA_OUT, SD_A_OUT        - bank and row/column/mode address
module sdram_cmd
  import SDRAM_PKG::*;
#(
  parameter int tRC   = 9,
  parameter int tRAS  = 6,
  parameter int tRP   = 3,
  parameter int tRCD  = 3,
  parameter int tMRD  = 2,
  parameter int tDPL  = 2,
  parameter int BANKS = 4
) (
  input  logic            CLK,
  input  logic            RESET_IN,
  input  cmd_t            CMD_DATA_IN,
  input  logic            CMD_REQ_IN,
  output logic            CMD_ACK_OUT,
  output logic            BANK_ACTIVE_OUT,
  output logic            ERROR_OUT,
  output logic            SD_CS_N,
  output logic            SD_RAS_N,
  output logic            SD_CAS_N,
  output logic            SD_WE_N,
  output logic [BA_W-1:0] SD_BA_OUT,
  output logic [A_W-1:0]  SD_A_OUT
);

  op_t             w_op;
  logic [BA_W-1:0] w_bank;
  logic            w_pall;
  logic            w_g_idle;
  logic            w_ready;
  logic            w_illegal;
  logic            w_issue;
  logic [3:0]      w_pins_nxt;
  logic [BA_W-1:0] w_ba_nxt;
  logic [A_W-1:0]  w_a_nxt;
  logic            w_unused_data;

  logic [BANKS-1:0] w_open, w_rp_ok, w_rcd_ok, w_ras_ok, w_rc_ok, w_dpl_ok;
  logic [BANKS-1:0] w_act_b, w_pre_b, w_wr_b;

  logic [CNT_W-1:0] r_gcnt;
  logic [3:0]       r_pins;
  logic [BA_W-1:0]  r_ba;
  logic [A_W-1:0]   r_a;
  logic             r_err;

  assign w_op          = CMD_DATA_IN.op;
  assign w_bank        = CMD_DATA_IN.bank;
  assign w_pall        = CMD_DATA_IN.addr[PALL_BIT];
  assign w_g_idle      = (r_gcnt == '0);
  assign w_unused_data = &{1'b0, CMD_DATA_IN.data[DQ_W-1:A_W]};

  // Timing readiness is judged independently of legality: an illegal
  // command still waits for its gaps before being acked and dropped.
  always_comb begin
    w_ready   = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_NOP:  w_ready = 1'b1;
      OP_MRS: begin
        w_ready   = w_g_idle;
        w_illegal = |w_open;
      end
      OP_REF: begin
        w_ready   = w_g_idle && (&w_rp_ok);
        w_illegal = |w_open;
      end
      OP_PRE:  w_ready = w_g_idle && (w_pall ? (&w_ras_ok && &w_dpl_ok)
                                             : (w_ras_ok[w_bank] && w_dpl_ok[w_bank]));
      OP_ACT: begin
        w_ready   = w_g_idle && w_rp_ok[w_bank] && w_rc_ok[w_bank];
        w_illegal = w_open[w_bank];
      end
      OP_READ, OP_WRITE: begin
        w_ready   = w_g_idle && w_rcd_ok[w_bank];
        w_illegal = !w_open[w_bank];
      end
      default: w_ready = 1'b0;
    endcase
  end

  assign CMD_ACK_OUT = CMD_REQ_IN && !RESET_IN && w_ready;
  assign w_issue     = CMD_ACK_OUT && !w_illegal && (w_op != OP_NOP);

  always_comb begin
    w_pins_nxt = PIN_NOP;
    w_ba_nxt   = '0;
    w_a_nxt    = '0;
    if (w_issue) begin
      w_ba_nxt = w_bank;
      case (w_op)
        OP_MRS: begin
          w_pins_nxt = PIN_MRS;
          w_a_nxt    = CMD_DATA_IN.data[A_W-1:0];
        end
        OP_REF:   w_pins_nxt = PIN_REF;
        OP_PRE: begin
          w_pins_nxt = PIN_PRE;
          w_a_nxt    = CMD_DATA_IN.addr;
        end
        OP_ACT: begin
          w_pins_nxt = PIN_ACT;
          w_a_nxt    = CMD_DATA_IN.addr;
        end
        OP_READ: begin
          w_pins_nxt = PIN_READ;
          w_a_nxt    = CMD_DATA_IN.addr;
        end
        OP_WRITE: begin
          w_pins_nxt = PIN_WRITE;
          w_a_nxt    = CMD_DATA_IN.addr;
        end
        default:  w_pins_nxt = PIN_NOP;
      endcase
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign w_act_b[b] = w_issue && (w_op == OP_ACT)   && (w_bank == BA_W'(b));
    assign w_wr_b[b]  = w_issue && (w_op == OP_WRITE) && (w_bank == BA_W'(b));
    assign w_pre_b[b] = w_issue && (w_op == OP_PRE)   && (w_pall || (w_bank == BA_W'(b)));

    sdram_bank_timer #(
      .tRC  (tRC),
      .tRAS (tRAS),
      .tRP  (tRP),
      .tRCD (tRCD),
      .tDPL (tDPL)
    ) u_timer (
      .i_clk    (CLK),
      .i_rst    (RESET_IN),
      .i_act    (w_act_b[b]),
      .i_pre    (w_pre_b[b]),
      .i_wr     (w_wr_b[b]),
      .o_open   (w_open[b]),
      .o_rp_ok  (w_rp_ok[b]),
      .o_rcd_ok (w_rcd_ok[b]),
      .o_ras_ok (w_ras_ok[b]),
      .o_rc_ok  (w_rc_ok[b]),
      .o_dpl_ok (w_dpl_ok[b])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET_IN) begin
      r_gcnt <= '0;
      r_pins <= PIN_NOP;
      r_ba   <= '0;
      r_a    <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pins <= w_pins_nxt;
      r_ba   <= w_ba_nxt;
      r_a    <= w_a_nxt;
      r_err  <= CMD_ACK_OUT && w_illegal;
      if (w_issue && (w_op == OP_MRS))      r_gcnt <= cnt_load(tMRD);
      else if (w_issue && (w_op == OP_REF)) r_gcnt <= cnt_load(tRC);
      else                                  r_gcnt <= cnt_dec(r_gcnt);
    end
  end

  assign {SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N} = r_pins;
  assign SD_BA_OUT       = r_ba;
  assign SD_A_OUT        = r_a;
  assign ERROR_OUT       = r_err;
  // Open flags are flops, so the OR follows an accept by one cycle.
  assign BANK_ACTIVE_OUT = |w_open;

endmodule
